// File: rtl/vga_text_cursor_if.sv
// Signal bundle between the VGA sync/register blocks and the text cursor stage.
// The master side drives timing strobes and cursor settings; the slave returns address and overlay.
interface vga_text_cursor_if;
    logic        frame_start;
    logic        line_end;
    logic        pixel_valid;
    logic        cursor_enabled;
    logic        graphics_enabled;
    logic [14:0] cursor_pos;
    logic [2:0]  cursor_scan_start;
    logic [2:0]  cursor_scan_end;
    logic [14:0] char_addr;
    logic [2:0]  glyph_row;
    logic        cursor_valid;
    logic        cursor_on;

    modport master (
        output frame_start, line_end, pixel_valid,
        output cursor_enabled, graphics_enabled,
        output cursor_pos, cursor_scan_start, cursor_scan_end,
        input  char_addr, glyph_row, cursor_valid, cursor_on
    );

    modport slave (
        input  frame_start, line_end, pixel_valid,
        input  cursor_enabled, graphics_enabled,
        input  cursor_pos, cursor_scan_start, cursor_scan_end,
        output char_addr, glyph_row, cursor_valid, cursor_on
    );
endinterface

// File: rtl/vga_text_cursor.sv
// Text-mode character scan address and cursor overlay in the VGA pixel clock domain.
// Define VGA_CURSOR_BLINK_EN to build the frame blink counter; otherwise the cursor is steady.
module vga_text_cursor #(
    parameter int COLS         = 80,
    parameter int ROWS         = 25,
    parameter int BLINK_FRAMES = 16
) (
    input  logic             clk,
    input  logic             reset,
    vga_text_cursor_if.slave bus
);

    localparam logic [14:0] LAST_CELL = 15'(ROWS * COLS - 1);
    localparam logic [14:0] COLS_W    = 15'(COLS);

    logic [14:0] row_base;
    logic [2:0]  pix_cnt;
    logic        blink_phase;
    logic        in_shape;
    logic        overlay;
    logic [14:0] next_row;

    function automatic logic [14:0] clamp_cell(input logic [14:0] a);
        return (a > LAST_CELL) ? LAST_CELL : a;
    endfunction

    assign next_row = row_base + COLS_W;

    // Split cursor (start > end) wraps around the bottom of the glyph cell.
    always_comb begin
        in_shape = 1'b0;
        if (bus.cursor_scan_start <= bus.cursor_scan_end)
            in_shape = (bus.glyph_row >= bus.cursor_scan_start) &&
                       (bus.glyph_row <= bus.cursor_scan_end);
        else
            in_shape = (bus.glyph_row >= bus.cursor_scan_start) ||
                       (bus.glyph_row <= bus.cursor_scan_end);
        overlay = bus.cursor_enabled & ~bus.graphics_enabled & blink_phase &
                  (bus.char_addr == bus.cursor_pos) & in_shape;
    end

    // Overlay is judged on the pre-update address/row; line_end then frame_start override counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.char_addr    <= '0;
            bus.glyph_row    <= '0;
            bus.cursor_valid <= 1'b0;
            bus.cursor_on    <= 1'b0;
            row_base         <= '0;
            pix_cnt          <= '0;
        end else begin
            bus.cursor_valid <= bus.pixel_valid;
            bus.cursor_on    <= bus.pixel_valid & overlay;
            if (bus.frame_start) begin
                row_base      <= '0;
                bus.char_addr <= '0;
                bus.glyph_row <= '0;
                pix_cnt       <= '0;
            end else if (bus.line_end) begin
                pix_cnt <= '0;
                if (bus.glyph_row == 3'd7) begin
                    bus.glyph_row <= '0;
                    row_base      <= next_row;
                    bus.char_addr <= clamp_cell(next_row);
                end else begin
                    bus.glyph_row <= bus.glyph_row + 3'd1;
                    bus.char_addr <= clamp_cell(row_base);
                end
            end else if (bus.pixel_valid) begin
                pix_cnt <= pix_cnt + 3'd1;
                if (pix_cnt == 3'd7 && bus.char_addr < LAST_CELL)
                    bus.char_addr <= bus.char_addr + 15'd1;
            end
        end
    end

`ifdef VGA_CURSOR_BLINK_EN
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FCW-1:0] frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (bus.frame_start) begin
            if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    // Steady cursor: true for any legal BLINK_FRAMES.
    assign blink_phase = (BLINK_FRAMES > 0);
`endif

endmodule
